// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizing constants, FSM state encoding and the sprite
// table entry layout used by the per-scanline sprite scheduler.
//   CORDW      signed coordinate width
//   NUM_SPR    sprite table entries, NUM_SLOTS sprite engines per line
//   IDW / SLW  table index width / slot index width (minimum 1)
package sprite_pkg;

   localparam int CORDW     = 16;
   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int SPR_DRAWH = 64;
   localparam int NUM_SPR   = 4;
   localparam int NUM_SLOTS = 2;
   localparam int IDW       = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
   localparam int SLW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      ISSUE = 2'd2,
      FILL  = 2'd3
   } state_t;

   typedef struct packed {
      logic             en;
      logic [CORDW-1:0] x;
      logic [CORDW-1:0] y;
   } sprite_t;

endpackage

// File: rtl/sprite_line_scheduler_table.sv
// sprite_table: NUM_SPR-entry sprite register file.
//   clk, rst_n     clock, asynchronous active-low reset (clears every entry)
//   we/widx/wdata  single write port, written at the clock edge
//   ridx/rdata     combinational read port
module sprite_table
   import sprite_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [IDW-1:0] widx,
   input  sprite_t        wdata,
   input  logic [IDW-1:0] ridx,
   output sprite_t        rdata
);

   sprite_t mem [NUM_SPR];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SPR; i++) mem[i] <= '0;
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: on each line pulse, scans the sprite table for
// entries that intersect the next scanline and issues exactly NUM_SLOTS slot
// loads (hits first in ascending index, then empty fills) to the engines.
//   clk_25MHz, btn_rst_n   pixel clock, asynchronous active-low reset
//   line, sy               start-of-line pulse and current line number
//   cfg_*                  sprite table write port
//   load_*                 slot load channel: a transfer happens on every
//                          clock edge where load_valid && load_ready; once
//                          load_valid rises it and all load_* fields hold
//                          until that transfer, and load_ready is ignored
//                          while load_valid is low
//   busy, overflow, late   status: not idle, more hits than slots on the
//                          last scheduled line, line arrived while busy
module sprite_line_scheduler
   import sprite_pkg::*;
(
   input  logic             clk_25MHz,
   input  logic             btn_rst_n,
   input  logic             line,
   input  logic [CORDW-1:0] sy,
   input  logic             cfg_we,
   input  logic [IDW-1:0]   cfg_idx,
   input  logic             cfg_en,
   input  logic [CORDW-1:0] cfg_x,
   input  logic [CORDW-1:0] cfg_y,
   output logic             load_valid,
   input  logic             load_ready,
   output logic [SLW-1:0]   load_slot,
   output logic             load_en,
   output logic [IDW-1:0]   load_idx,
   output logic [CORDW-1:0] load_x,
   output logic [CORDW-1:0] load_y,
   output logic             busy,
   output logic             overflow,
   output logic             late
);

   // slot counter must be able to hold NUM_SLOTS itself ("all slots used")
   localparam int              CNTW     = SLW + 1;
   localparam logic [CNTW-1:0] SLOTS_N  = CNTW'(NUM_SLOTS);
   localparam logic [IDW-1:0]  LAST_IDX = IDW'(NUM_SPR - 1);

   state_t                state, state_nx;
   logic signed [CORDW:0] next_y;
   logic [IDW-1:0]        scan_idx;
   logic [CNTW-1:0]       slot_cnt, slot_inc;
   logic                  pend;
   logic [IDW-1:0]        hit_idx;
   logic [CORDW-1:0]      hit_x, hit_y;
   sprite_t               wr_entry, entry;
   logic signed [CORDW:0] y_lo, y_hi;
   logic                  hit, slot_free, last, handshake, take_line, restart;

   assign wr_entry = '{en: cfg_en, x: cfg_x, y: cfg_y};

   sprite_table u_table (
      .clk   (clk_25MHz),
      .rst_n (btn_rst_n),
      .we    (cfg_we),
      .widx  (cfg_idx),
      .wdata (wr_entry),
      .ridx  (scan_idx),
      .rdata (entry)
   );

   // one extra bit so y + SPR_DRAWH and sy + 1 can never wrap
   assign y_lo      = {entry.y[CORDW-1], entry.y};
   assign y_hi      = y_lo + (CORDW+1)'(SPR_DRAWH);
   assign hit       = entry.en && (next_y >= y_lo) && (next_y < y_hi);
   assign slot_free = (slot_cnt < SLOTS_N);
   assign slot_inc  = slot_cnt + CNTW'(1);
   assign last      = (scan_idx == LAST_IDX);
   assign handshake = load_valid && load_ready;
   // a line seen while busy waits in pend until no transfer is in flight
   assign take_line = line || pend;
   assign restart   = (state != IDLE) && take_line && ((state == SCAN) || handshake);

   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (line) state_nx = SCAN;
         SCAN: begin
            if (take_line)              state_nx = SCAN;
            else if (hit && slot_free)  state_nx = ISSUE;
            else if (last)              state_nx = slot_free ? FILL : IDLE;
         end
         ISSUE: if (handshake) begin
            if (take_line || !last)     state_nx = SCAN;
            else                        state_nx = (slot_inc < SLOTS_N) ? FILL : IDLE;
         end
         FILL: if (handshake) begin
            if (take_line)              state_nx = SCAN;
            else if (slot_inc >= SLOTS_N) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_valid = 1'b0;
      load_en    = 1'b0;
      load_slot  = '0;
      load_idx   = '0;
      load_x     = '0;
      load_y     = '0;
      case (state)
         ISSUE: begin
            load_valid = 1'b1;
            load_en    = 1'b1;
            load_slot  = slot_cnt[SLW-1:0];
            load_idx   = hit_idx;
            load_x     = hit_x;
            load_y     = hit_y;
         end
         FILL: begin
            load_valid = 1'b1;
            load_slot  = slot_cnt[SLW-1:0];
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk_25MHz or negedge btn_rst_n) begin
      if (!btn_rst_n) begin
         next_y   <= '0;
         scan_idx <= '0;
         slot_cnt <= '0;
         pend     <= 1'b0;
         overflow <= 1'b0;
         late     <= 1'b0;
         hit_idx  <= '0;
         hit_x    <= '0;
         hit_y    <= '0;
      end else begin
         late <= line && (state != IDLE);
         if (line) next_y <= {sy[CORDW-1], sy} + (CORDW+1)'(1);
         if (((state == IDLE) && line) || restart) begin
            scan_idx <= '0;
            slot_cnt <= '0;
            overflow <= 1'b0;
            pend     <= 1'b0;
         end else begin
            if (line) pend <= 1'b1;
            case (state)
               SCAN: begin
                  // latch the hit so load_* stay stable even if the table is rewritten
                  if (hit && slot_free) begin
                     hit_idx <= scan_idx;
                     hit_x   <= entry.x;
                     hit_y   <= entry.y;
                  end else begin
                     scan_idx <= scan_idx + 1'b1;
                  end
                  if (hit && !slot_free) overflow <= 1'b1;
               end
               ISSUE: if (handshake) begin
                  slot_cnt <= slot_inc;
                  scan_idx <= scan_idx + 1'b1;
               end
               FILL: if (handshake) slot_cnt <= slot_inc;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/sprite_line_scheduler.md
Name: sprite_line_scheduler

Overview:
- Per-scanline scheduler that shares a fixed number of sprite-engine slots among a larger table of sprites.
- On each line-start pulse it scans the sprite table for sprites that intersect the next line.
- It then issues exactly one load transaction per slot, over a valid/ready handshake, to the sprite draw engines.
- It sits between the game/CPU-side position writer and the sprite renderers in the 25 MHz pixel domain.

Parameters:
CORDW, 16, signed coordinate width (bits)
NUM_SPR, 4, sprite table entries
NUM_SLOTS, 2, sprite engines available per line
SPR_DRAWH, 64, scaled sprite draw height (pixels)
IDW, 2, index width = clog2(NUM_SPR); SLW = clog2(NUM_SLOTS), minimum 1

Ports:
clk_25MHz  in  1  pixel clock
btn_rst_n  in  1  asynchronous active-low reset
line  in  1  one-cycle pulse at start of line
sy  in  CORDW  current line number (signed)
cfg_we  in  1  sprite table write strobe
cfg_idx  in  IDW  table entry written
cfg_en  in  1  entry enable
cfg_x  in  CORDW  entry x position
cfg_y  in  CORDW  entry y position
load_valid  out  1  slot load offered
load_ready  in  1  engine accepts load
load_slot  out  SLW  target slot
load_en  out  1  1 = sprite assigned, 0 = slot unused this line
load_idx  out  IDW  table index of sprite
load_x  out  CORDW  sprite x
load_y  out  CORDW  sprite y
busy  out  1  FSM not IDLE
overflow  out  1  more hits than slots on last scheduled line
late  out  1  one-cycle pulse: line arrived while busy

Behaviour:
- Reset (async assert, sync release): all outputs 0; every table entry en=0, x=0, y=0; FSM in IDLE; target line, scan index and slot counter cleared.
- Table writes: take effect at the clock edge. The FSM reads registered values, so a write is visible the cycle after cfg_we. A write to an already-scanned index applies from the next line.
- Hit test: en && next_y >= y && next_y < y + SPR_DRAWH.
  - Signed compare, evaluated at CORDW+1 bits so no overflow.
  - next_y = sy + 1, latched when the line pulse is accepted. No wrap.
- FSM states:
  - IDLE: on line, latch next_y, clear scan index, slot counter and overflow → SCAN.
  - SCAN: test one entry per cycle.
    - Hit with a free slot → ISSUE.
    - Hit with no free slot → set overflow and continue scanning.
    - Last entry tested → FILL.
  - ISSUE: drive load_valid=1, load_en=1, load_slot = slot counter, idx/x/y of the hit entry.
    - Hold all load_* stable until load_ready.
    - On handshake, increment the slot counter; return to SCAN at the next index, or go to FILL if that was the last entry.
  - FILL: for each remaining slot, drive load_valid=1, load_en=0, load_idx/x/y = 0.
    - Advance on each handshake; after the last slot → IDLE.
- Handshake rules:
  - load_valid never drops without load_ready.
  - load_ready while load_valid=0 is ignored.
- Every accepted line produces exactly NUM_SLOTS handshakes, slots in ascending order, hits in ascending table index.
- Latency: line at cycle T → SCAN at T+1. The earliest load_valid is T+2 (entry 0 hit).
  - With load_ready tied high, worst case is NUM_SPR + NUM_SLOTS + 1 cycles, well inside the 160-cycle horizontal blank.
- Line pulse while busy:
  - Pulse late for one cycle.
  - Latch the new next_y.
  - Let any in-flight handshake complete, then restart the scan for the new line without finishing FILL for the old one. Slot numbering restarts at 0.
- overflow: updated only at line accept (cleared) and during SCAN (set). It holds until the next accepted line.
- busy = (state != IDLE).
- Reset mid-operation: immediate return to IDLE with load_valid=0.

Decomposition:
- Package sprite_pkg holds:
  - CORDW, H_RES=640, V_RES=480, SPR_DRAWH;
  - the FSM state enum (IDLE, SCAN, ISSUE, FILL);
  - a sprite entry struct (en, x, y).
- One sub-module, sprite_table: NUM_SPR-entry register file with a single write port, one combinational read port, and async active-low reset.

Test Plan:
- Reset, no config, line with sy=100, load_ready=1 → two handshakes: slot0 and slot1 both load_en=0; overflow=0; busy low after FILL.
- Entry0 en, x=288, y=208; line with sy=207 → slot0 load_en=1, idx0, x=288, y=208; slot1 load_en=0. A line with sy=271 (next_y=272) → no hit.
- Entries 0,1,2 all y=100, en; line with sy=120 → slot0 idx0, slot1 idx1; overflow=1. The next line with sy=300 clears overflow.
- Entry3 only en, y=-30; line with sy=20 → slot0 idx3 (-30 ≤ 21 < 34). Then hold load_ready=0 for 5 cycles → load_valid and load_* stay stable.
- Second line pulse issued 2 cycles after the first while load_ready=0 → late pulses once; after ready, the scan restarts with the new next_y; exactly NUM_SLOTS handshakes follow for the new line.
- Assert btn_rst_n=0 during ISSUE → load_valid falls immediately, table cleared; the next line yields two load_en=0 slots.
